// File: rtl/debug_snapshot_streamer_if.sv
// UART RX/TX byte handshake plus the data-RAM read port owned by the debug streamer.
interface debug_snapshot_streamer_if #(
    parameter int WORD_W = 32,
    parameter int RAM_AW = 8
) ();
    logic [7:0]        rx_data;
    logic              rx_available;
    logic              rx_read;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              ram_src;
    logic [RAM_AW-1:0] ram_addr;
    logic [WORD_W-1:0] ram_data;

    modport master (
        input  rx_data, rx_available, tx_ready, ram_data,
        output rx_read, tx_data, tx_valid, ram_src, ram_addr
    );

    modport slave (
        output rx_data, rx_available, tx_ready, ram_data,
        input  rx_read, tx_data, tx_valid, ram_src, ram_addr
    );
endinterface

// File: rtl/debug_snapshot_streamer.sv
// UART-driven step/run controller that streams a snapshot + RAM dump + trailer per halt.
// All outputs registered; one byte per accepted transfer, waits indefinitely on tx_ready low.
module debug_snapshot_streamer #(
    parameter int          WORD_W         = 32,
    parameter int          NUM_WORDS      = 16,
    parameter int          RAM_AW         = 8,
    parameter int          RAM_DUMP_WORDS = 32,
    parameter logic [7:0]  CMD_STEP       = 8'h73,
    parameter logic [7:0]  CMD_CONT       = 8'h63,
    parameter logic [7:0]  CMD_RESET      = 8'h72,
    parameter logic [7:0]  TRAILER        = 8'hFF
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    debug_snapshot_streamer_if.master   bus,
    input  logic                        end_of_program_i,
    input  logic [NUM_WORDS*WORD_W-1:0] snapshot_bus_i,
    output logic                        pipe_enable_o,
    output logic                        pipe_reset_o,
    output logic                        led_idle_o,
    output logic                        led_step_o,
    output logic                        led_run_o,
    output logic                        led_send_o,
    output logic [15:0]                 sent_count_o
);
    localparam int BPW       = WORD_W / 8;
    localparam int SR_W      = NUM_WORDS * WORD_W;
    localparam int REG_BYTES = NUM_WORDS * BPW;
    localparam int BC_W      = $clog2(REG_BYTES + 1);
    localparam int LAST_RAM  = (RAM_DUMP_WORDS > 0) ? RAM_DUMP_WORDS - 1 : 0;

    typedef enum logic [3:0] {
        S_IDLE, S_STEP, S_RUN, S_CAPTURE, S_SEND_REGS,
        S_RAM_ADDR, S_RAM_WAIT, S_SEND_RAM, S_SEND_TRAIL
    } state_e;

    state_e            state_q, state_d;
    logic [SR_W-1:0]   sr_q, sr_d, cap_sr;
    logic [BC_W-1:0]   bcnt_q, bcnt_d;
    logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
    logic              ram_src_q, ram_src_d;
    logic              tx_valid_q, tx_valid_d;
    logic              rx_read_q, rx_read_d;
    logic              pipe_en_q, pipe_en_d;
    logic              pipe_rst_q, pipe_rst_d;
    logic [15:0]       sent_q, sent_d;
    logic [3:0]        led_q, led_d;
    logic              xfer;

    // Reorder so word 0 sits at the top: the outgoing byte is always sr_q's top byte.
    for (genvar k = 0; k < NUM_WORDS; k++) begin : g_cap
        assign cap_sr[(NUM_WORDS-1-k)*WORD_W +: WORD_W] = snapshot_bus_i[k*WORD_W +: WORD_W];
    end

    assign xfer = tx_valid_q & bus.tx_ready;

    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        bcnt_d     = bcnt_q;
        ram_addr_d = ram_addr_q;
        ram_src_d  = ram_src_q;
        tx_valid_d = tx_valid_q;
        rx_read_d  = 1'b0;
        pipe_en_d  = 1'b0;
        pipe_rst_d = 1'b0;
        sent_d     = sent_q;
        if (xfer && sent_q != 16'hFFFF) begin
            sent_d = sent_q + 16'd1;
        end

        case (state_q)
            S_IDLE: begin
                // Skip the cycle the pop is in flight: the FIFO head is still the old byte.
                if (bus.rx_available && !rx_read_q) begin
                    rx_read_d = 1'b1;
                    if (bus.rx_data == CMD_STEP) begin
                        state_d   = S_STEP;
                        pipe_en_d = 1'b1;
                    end else if (bus.rx_data == CMD_CONT) begin
                        state_d   = S_RUN;
                        pipe_en_d = 1'b1;
                    end else if (bus.rx_data == CMD_RESET) begin
                        pipe_rst_d = 1'b1;
                    end
                end
            end
            S_STEP: state_d = S_CAPTURE;
            S_RUN: begin
                if (end_of_program_i) begin
                    state_d = S_CAPTURE;
                end else begin
                    pipe_en_d = 1'b1;
                end
            end
            S_CAPTURE: begin
                sr_d       = cap_sr;
                bcnt_d     = BC_W'(REG_BYTES - 1);
                sent_d     = 16'd0;
                ram_addr_d = '0;
                tx_valid_d = 1'b1;
                state_d    = S_SEND_REGS;
            end
            S_SEND_REGS: begin
                if (xfer) begin
                    sr_d = sr_q << 8;
                    if (bcnt_q == '0) begin
                        tx_valid_d = 1'b0;
                        if (RAM_DUMP_WORDS > 0) begin
                            state_d   = S_RAM_ADDR;
                            ram_src_d = 1'b1;
                        end else begin
                            state_d             = S_SEND_TRAIL;
                            sr_d[SR_W-1 -: 8]   = TRAILER;
                            tx_valid_d          = 1'b1;
                        end
                    end else begin
                        bcnt_d = bcnt_q - 1'b1;
                    end
                end
            end
            S_RAM_ADDR: state_d = S_RAM_WAIT;
            S_RAM_WAIT: begin
                sr_d[SR_W-1 -: WORD_W] = bus.ram_data;
                bcnt_d                 = BC_W'(BPW - 1);
                tx_valid_d             = 1'b1;
                state_d                = S_SEND_RAM;
            end
            S_SEND_RAM: begin
                if (xfer) begin
                    sr_d = sr_q << 8;
                    if (bcnt_q == '0) begin
                        if (ram_addr_q == RAM_AW'(LAST_RAM)) begin
                            state_d           = S_SEND_TRAIL;
                            ram_src_d         = 1'b0;
                            ram_addr_d        = '0;
                            sr_d[SR_W-1 -: 8] = TRAILER;
                        end else begin
                            tx_valid_d = 1'b0;
                            ram_addr_d = ram_addr_q + 1'b1;
                            state_d    = S_RAM_ADDR;
                        end
                    end else begin
                        bcnt_d = bcnt_q - 1'b1;
                    end
                end
            end
            S_SEND_TRAIL: begin
                if (xfer) begin
                    tx_valid_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        case (state_d)
            S_IDLE:  led_d = 4'b0001;
            S_STEP:  led_d = 4'b0010;
            S_RUN:   led_d = 4'b0100;
            default: led_d = 4'b1000;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            sr_q       <= '0;
            bcnt_q     <= '0;
            ram_addr_q <= '0;
            ram_src_q  <= 1'b0;
            tx_valid_q <= 1'b0;
            rx_read_q  <= 1'b0;
            pipe_en_q  <= 1'b0;
            pipe_rst_q <= 1'b0;
            sent_q     <= 16'd0;
            led_q      <= 4'b0001;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            bcnt_q     <= bcnt_d;
            ram_addr_q <= ram_addr_d;
            ram_src_q  <= ram_src_d;
            tx_valid_q <= tx_valid_d;
            rx_read_q  <= rx_read_d;
            pipe_en_q  <= pipe_en_d;
            pipe_rst_q <= pipe_rst_d;
            sent_q     <= sent_d;
            led_q      <= led_d;
        end
    end

    assign bus.rx_read    = rx_read_q;
    assign bus.tx_data    = sr_q[SR_W-1 -: 8];
    assign bus.tx_valid   = tx_valid_q;
    assign bus.ram_src    = ram_src_q;
    assign bus.ram_addr   = ram_addr_q;
    assign pipe_enable_o  = pipe_en_q;
    assign pipe_reset_o   = pipe_rst_q;
    assign led_idle_o     = led_q[0];
    assign led_step_o     = led_q[1];
    assign led_run_o      = led_q[2];
    assign led_send_o     = led_q[3];
    assign sent_count_o   = sent_q;
endmodule

// File: tb/tb_debug_snapshot_streamer.sv
// Bench for debug_snapshot_streamer: frame-level reference model with randomized stimulus.
module tb_debug_snapshot_streamer;
    localparam int WORD_W         = 32;
    localparam int NUM_WORDS      = 2;
    localparam int RAM_AW         = 8;
    localparam int RAM_DUMP_WORDS = 2;
    localparam int BPW            = WORD_W / 8;
    localparam int FRAME_LEN      = (NUM_WORDS + RAM_DUMP_WORDS) * BPW + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    debug_snapshot_streamer_if #(.WORD_W(WORD_W), .RAM_AW(RAM_AW)) bus ();

    logic                        eop = 1'b0;
    logic [NUM_WORDS*WORD_W-1:0] snap = '0;
    logic                        pe, pr, li, ls, lr, lsd;
    logic [15:0]                 sc;

    debug_snapshot_streamer #(
        .WORD_W(WORD_W), .NUM_WORDS(NUM_WORDS), .RAM_AW(RAM_AW), .RAM_DUMP_WORDS(RAM_DUMP_WORDS)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus), .end_of_program_i(eop), .snapshot_bus_i(snap),
        .pipe_enable_o(pe), .pipe_reset_o(pr), .led_idle_o(li), .led_step_o(ls),
        .led_run_o(lr), .led_send_o(lsd), .sent_count_o(sc)
    );

    // Environment models: RX FIFO, synchronous-read RAM, TX ready pattern.
    logic [7:0]  rx_q [$];
    logic [31:0] ram_mem [256];
    int          rdy_mode = 0;
    bit          rx_pop;

    always @(posedge clk) begin
        rx_pop = bus.rx_read;
        #1;
        if (rx_pop && rx_q.size() > 0) void'(rx_q.pop_front());
        bus.rx_available = (rx_q.size() > 0);
        bus.rx_data      = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
    end

    always @(posedge clk) bus.ram_data <= ram_mem[bus.ram_addr];

    always @(posedge clk) begin
        #3;
        case (rdy_mode)
            0:       bus.tx_ready = 1'b1;
            1:       bus.tx_ready = !bus.tx_ready;
            2:       bus.tx_ready = 1'($urandom_range(0, 1));
            default: bus.tx_ready = 1'b0;
        endcase
    end

    int n_pass = 0;
    int n_chk  = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Expected frame: each snapshot word then each RAM word, MSB byte first, then trailer.
    logic [7:0] exp_q [$];
    logic [7:0] act_q [$];

    task automatic load_frame(input logic [NUM_WORDS*WORD_W-1:0] s);
        logic [WORD_W-1:0] w;
        for (int i = 0; i < NUM_WORDS; i++) begin
            w = s[i*WORD_W +: WORD_W];
            for (int b = 0; b < BPW; b++) exp_q.push_back(w[WORD_W-1-8*b -: 8]);
        end
        for (int r = 0; r < RAM_DUMP_WORDS; r++) begin
            w = ram_mem[r];
            for (int b = 0; b < BPW; b++) exp_q.push_back(w[WORD_W-1-8*b -: 8]);
        end
        exp_q.push_back(8'hFF);
    endtask

    int         pe_cnt = 0, rr_cnt = 0, pr_cnt = 0, tv_cnt = 0, rs_cnt = 0, xfer_cnt = 0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_dat;
    logic [7:0] mon_e;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (pe) pe_cnt++;
            if (bus.rx_read) rr_cnt++;
            if (pr) pr_cnt++;
            if (bus.tx_valid) tv_cnt++;
            if (bus.ram_src) rs_cnt++;
            check("led_onehot", 64'($onehot({li, ls, lr, lsd})), 1);
            if (prev_stall) begin
                check("tx_hold_valid", bus.tx_valid, 1);
                check("tx_hold_data", bus.tx_data, prev_dat);
            end
            if (bus.tx_valid && bus.tx_ready) begin
                xfer_cnt++;
                act_q.push_back(bus.tx_data);
                mon_e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                check("tx_byte", bus.tx_data, mon_e);
                check("tx_pipe_halted", pe, 0);
            end
            prev_stall = bus.tx_valid && !bus.tx_ready;
            prev_dat   = bus.tx_data;
        end
    end

    task automatic wait_frame(input int max_cyc);
        int i = 0;
        while (i < max_cyc && !(exp_q.size() == 0 && li && !bus.tx_valid)) begin
            @(negedge clk);
            i++;
        end
        check("frame_complete", i < max_cyc, 1);
    endtask

    // One halt/dump cycle: command, n_run enabled pipeline cycles, then the full frame.
    task automatic do_frame(input bit cont, input int n_run, input int mode);
        int b_pe, b_x, k;
        @(posedge clk); #2;
        rdy_mode = mode;
        load_frame(snap);
        b_pe = pe_cnt;
        b_x  = xfer_cnt;
        rx_q.push_back(cont ? 8'h63 : 8'h73);
        k = 0;
        for (int g = 0; g < 200; g++) begin
            @(posedge clk); #2;
            if (pe) begin
                k++;
                if (k == n_run) eop = 1'b1;
            end else if (eop) begin
                break;
            end
        end
        eop = 1'b0;
        check("pipe_enable_cycles", pe_cnt - b_pe, n_run);
        wait_frame(800);
        check("sent_count", sc, FRAME_LEN);
        check("frame_bytes", xfer_cnt - b_x, FRAME_LEN);
        check("ram_src_released", bus.ram_src, 0);
    endtask

    logic [7:0] lit [17] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44,
                             8'h00, 8'h00, 8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hFF};

    initial begin
        int b_x, b_rs, b_rr, b_pr, b_tv, b_pe;
        for (int i = 0; i < 256; i++) ram_mem[i] = 32'h0;
        ram_mem[0] = 32'h0000_0001;
        ram_mem[1] = 32'hDEAD_BEEF;

        // Reset held with a byte waiting in RX: nothing may be popped.
        rx_q.push_back(8'h78);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rst_rx_read", bus.rx_read, 0);
        end
        check("rst_tx_valid", bus.tx_valid, 0);
        check("rst_tx_data", bus.tx_data, 0);
        check("rst_pipe_en", pe, 0);
        check("rst_pipe_rst", pr, 0);
        check("rst_ram_src", bus.ram_src, 0);
        check("rst_ram_addr", bus.ram_addr, 0);
        check("rst_sent", sc, 0);
        check("rst_leds", {li, ls, lr, lsd}, 4'b1000);
        @(posedge clk); #2;
        rst_n = 1'b1;
        b_rr = rr_cnt; b_tv = tv_cnt;
        repeat (6) @(negedge clk);
        check("junk_popped", rr_cnt - b_rr, 1);
        check("junk_no_tx", tv_cnt - b_tv, 0);
        check("junk_idle", li, 1);

        // Single step, ready always high; byte stream pinned to literal values.
        snap = 64'h11223344_AABBCCDD;
        b_x  = xfer_cnt;
        b_rs = rs_cnt;
        do_frame(1'b0, 1, 0);
        for (int i = 0; i < 17; i++)
            check("step_literal", (act_q.size() > b_x + i) ? act_q[b_x+i] : 8'hxx, lit[i]);
        check("ram_src_cycles", rs_cnt - b_rs, 12);

        // Same frame under toggling ready.
        do_frame(1'b0, 1, 1);

        // Continue: end_of_program on the 10th enabled cycle.
        snap = {$urandom, $urandom};
        do_frame(1'b1, 10, 0);

        // Reset command then an unknown byte.
        @(posedge clk); #2;
        b_rr = rr_cnt; b_pr = pr_cnt; b_tv = tv_cnt; b_pe = pe_cnt;
        rx_q.push_back(8'h72);
        rx_q.push_back(8'h78);
        repeat (10) @(negedge clk);
        check("cmd_rx_pops", rr_cnt - b_rr, 2);
        check("cmd_pipe_reset", pr_cnt - b_pr, 1);
        check("cmd_no_tx", tv_cnt - b_tv, 0);
        check("cmd_no_enable", pe_cnt - b_pe, 0);
        check("cmd_idle", li, 1);

        // Abort a frame while the third register byte is on the bus.
        @(posedge clk); #2;
        rdy_mode = 0;
        snap = {$urandom, $urandom};
        load_frame(snap);
        b_x = xfer_cnt;
        rx_q.push_back(8'h73);
        for (int g = 0; g < 100 && xfer_cnt - b_x < 2; g++) begin
            @(posedge clk); #2;
        end
        check("abort_reached", xfer_cnt - b_x, 2);
        rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_tx_valid", bus.tx_valid, 0);
        check("abort_ram_src", bus.ram_src, 0);
        check("abort_idle", li, 1);
        check("abort_sent", sc, 0);
        repeat (8) @(negedge clk);
        check("abort_no_more_bytes", xfer_cnt - b_x, 2);
        snap = {$urandom, $urandom};
        do_frame(1'b0, 1, 2);

        // Randomized frames: commands, run lengths, data and ready patterns.
        for (int t = 0; t < 6; t++) begin
            bit c;
            int n;
            snap       = {$urandom, $urandom};
            ram_mem[0] = $urandom;
            ram_mem[1] = $urandom;
            c = 1'($urandom_range(0, 1));
            n = c ? int'($urandom_range(1, 20)) : 1;
            do_frame(c, n, int'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, passed %0d of %0d", n_pass, n_chk);
        $fatal(1);
    end
endmodule
